vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised, multi-mode VGA timing generator: the next generation of the fixed 640x480 sync generator. Produces hsync/vsync/display-enable plus pixel coordinates and line/frame strobes for a runtime-selectable video mode, with per-mode sync polarity and a pixel-clock enable. It sits between the pixel-clock domain and the frame-buffer reader/pattern generators.

## Interface
- `CW`, 11, width of the horizontal/vertical counters and of the `x`/`y` outputs; must hold the largest total minus 1 (1055).
- `clk` in 1: pixel-domain clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: pixel enable; counters and outputs advance only on `clk` edges with `en=1`.
- `mode_sel` in 1: requested mode, 0 = 640x480@60, 1 = 800x600@60.
- `mode_active` out 1: mode currently being generated.
- `hsync` out 1: horizontal sync, polarity per mode.
- `vsync` out 1: vertical sync, polarity per mode.
- `de` out 1: display enable, 1 in the active region only.
- `x` out CW: registered horizontal count.
- `y` out CW: registered vertical count.
- `line_start` out 1: one-cycle strobe when `x` = 0.
- `frame_start` out 1: one-cycle strobe when `x` = 0 and `y` = 0.

## Operation
- Mode 0: H = 640/16/96/48 (total 800), V = 480/10/2/33 (total 525), both syncs active-low.
- Mode 1: H = 800/40/128/88 (total 1056), V = 600/1/4/23 (total 628), both syncs active-high.
- `h` increments on every `en` cycle and wraps to 0 after H_TOTAL-1.
- `v` increments when `h` wraps and wraps to 0 after V_TOTAL-1.
- Each axis has a phase FSM with states ACTIVE, FRONT, SYNC, BACK:
  - ACTIVE -> FRONT at count = DISPLAY-1
  - FRONT -> SYNC at DISPLAY+FRONT-1
  - SYNC -> BACK at DISPLAY+FRONT+SYNC-1
  - BACK -> ACTIVE at TOTAL-1
  - The V FSM evaluates only on H-wrap cycles.
  - Any illegal encoding -> ACTIVE with count 0.
- Output derivation:
  - `de` = (H phase == ACTIVE) and (V phase == ACTIVE).
  - sync = (phase == SYNC) XOR (polarity is active-low).
- Mode switching:
  - `mode_sel` is sampled only on the frame-wrap cycle (h = H_TOTAL-1, v = V_TOTAL-1, `en=1`).
  - The new mode applies from the next (0,0); the current frame is never truncated.
  - `mode_active` updates on the same edge the counters return to (0,0).
- `en=0` freezes counters, FSMs and `mode_active`.
  - `hsync`/`vsync`/`de`/`x`/`y` hold their values.
  - `line_start`/`frame_start` are forced to 0.

## Timing
- All outputs are registered, with 1-cycle latency from counter state: the output on the edge after an `en=1` cycle reflects the counter values of that cycle.
- Reset values: `mode_active`=0, `hsync`=1, `vsync`=1 (inactive for mode 0), `de`=0, `x`=0, `y`=0, `line_start`=0, `frame_start`=0; internal counters 0, both FSMs ACTIVE.
- The first `en` edge after reset release presents (0,0) with `frame_start`=1, `line_start`=1 and `de`=1.
- Asserting `rst` mid-frame forces reset values immediately, without a clock edge.
- Each strobe is exactly one `clk` cycle wide, even when `en` is high continuously.
- A `mode_sel` change at any time other than the frame-wrap cycle has no effect until that cycle.

## Structure
- `vga_pkg` holds:
  - `vga_phase_t` enum {ACTIVE, FRONT, SYNC, BACK}.
  - `vga_timing_t` packed struct: display, front, sync and back per axis, plus `hs_neg` and `vs_neg`.
  - Constants `VGA_640X480` and `VGA_800X600`.
  - Function `axis_total()`.
- Sub-module `vga_axis_counter`, instantiated once for H and once for V:
  - Inputs: `inc`, and the timing fields for its axis.
  - Outputs: count, phase, and `wrap` (inc && count == total-1).
- An elaboration-time assertion checks that `CW` covers both totals.

## Test plan
- Reset: hold `rst`=1 -> `hsync`=1, `vsync`=1, `de`=0, `x`=`y`=0, `mode_active`=0; release with `en`=1 -> `frame_start`=1 on the first edge.
- Mode 0 line, continuous `en`: `de`=1 for exactly 640 cycles, `hsync`=0 for `x`=656..751 (96 cycles), `line_start` every 800 cycles.
- Mode 0 frame: `frame_start` every 420000 `en` cycles; `vsync`=0 only for `y`=490..491; `de`=0 for `y`>=480.
- Mode switch: set `mode_sel`=1 at `y`=100 -> `mode_active` stays 0 until frame end, then next frame line = 1056, `hsync`=1 for `x`=840..967, `vsync`=1 for `y`=601..604.
- 50% `en` duty: the same `x`/`y` sequence at half rate, outputs held during `en`=0, strobes one `clk` wide.
- Async `rst` pulse at `x`=300, `y`=200 between clock edges -> outputs reach reset values immediately; after release, restart at (0,0) in mode 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and video-mode tables for the VGA timing generator.
//   vga_phase_t  : per-axis phase (active, front porch, sync, back porch)
//   vga_timing_t : display/front/sync/back lengths per axis plus sync polarities
//   VGA_640X480, VGA_800X600 : the two supported modes
//   axis_total() : total length of one axis (sum of its four regions)
package vga_pkg;

  localparam int unsigned TW = 11;

  typedef logic [TW-1:0] vga_len_t;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } vga_phase_t;

  typedef struct packed {
    vga_len_t h_display;
    vga_len_t h_front;
    vga_len_t h_sync;
    vga_len_t h_back;
    vga_len_t v_display;
    vga_len_t v_front;
    vga_len_t v_sync;
    vga_len_t v_back;
    logic     hs_neg;   // 1: hsync is active-low
    logic     vs_neg;   // 1: vsync is active-low
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_display: 11'd640, h_front: 11'd16, h_sync: 11'd96, h_back: 11'd48,
    v_display: 11'd480, v_front: 11'd10, v_sync: 11'd2,  v_back: 11'd33,
    hs_neg:    1'b1,    vs_neg:  1'b1
  };

  localparam vga_timing_t VGA_800X600 = '{
    h_display: 11'd800, h_front: 11'd40, h_sync: 11'd128, h_back: 11'd88,
    v_display: 11'd600, v_front: 11'd1,  v_sync: 11'd4,   v_back: 11'd23,
    hs_neg:    1'b0,    vs_neg:  1'b0
  };

  function automatic int unsigned axis_total(input vga_len_t display, input vga_len_t front,
                                             input vga_len_t sync, input vga_len_t back);
    return 32'(display) + 32'(front) + 32'(sync) + 32'(back);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator and its consumers
// (frame-buffer reader, pattern generators).
//   en, mode_sel           : pixel enable and requested mode (consumer -> generator)
//   mode_active            : mode currently being generated
//   hsync, vsync, de       : sync and display-enable
//   x, y                   : registered pixel coordinates
//   line_start, frame_start: one-cycle strobes at x==0 / (x,y)==(0,0)
interface vga_timing_gen_if #(
  parameter int unsigned CW = 11
);

  logic          en;
  logic          mode_sel;
  logic          mode_active;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  // The generator is the master of the timing stream.
  modport master (
    input  en, mode_sel,
    output mode_active, hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    output en, mode_sel,
    input  mode_active, hsync, vsync, de, x, y, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the VGA timing generator: a wrapping
// counter plus a phase FSM tracking which region the count is in.
//   clk, rst                     : clock, async active-high reset
//   inc                          : advance count (and phase) this cycle
//   display, front, sync, back   : region lengths for this axis
//   count                        : current count
//   phase                        : region of the current count
//   wrap                         : inc && count == total-1
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [CW-1:0] display,
  input  logic [CW-1:0] front,
  input  logic [CW-1:0] sync,
  input  logic [CW-1:0] back,
  output logic [CW-1:0] count,
  output vga_phase_t    phase,
  output logic          wrap
);

  logic [CW-1:0] count_q;
  vga_phase_t    phase_q;

  // Last count of each region.
  logic [CW-1:0] active_end;
  logic [CW-1:0] front_end;
  logic [CW-1:0] sync_end;
  logic [CW-1:0] last;

  assign active_end = display - 1'b1;
  assign front_end  = active_end + front;
  assign sync_end   = front_end + sync;
  assign last       = sync_end + back;

  assign wrap = inc && (count_q == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= ACTIVE;
    end else begin
      if (inc) begin
        count_q <= (count_q == last) ? '0 : count_q + 1'b1;
      end
      case (phase_q)
        ACTIVE: if (inc && (count_q == active_end)) phase_q <= FRONT;
        FRONT:  if (inc && (count_q == front_end))  phase_q <= SYNC;
        SYNC:   if (inc && (count_q == sync_end))   phase_q <= BACK;
        BACK:   if (inc && (count_q == last))       phase_q <= ACTIVE;
        default: begin
          // Unreachable encoding: recover to the start of the axis.
          phase_q <= ACTIVE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign phase = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Multi-mode VGA timing generator (640x480@60 / 800x600@60).
//   clk  : pixel-domain clock
//   rst  : asynchronous active-high reset
//   bus  : vga_timing_gen_if master modport
//          in : en (pixel enable), mode_sel (requested mode, taken at frame end)
//          out: mode_active, hsync, vsync, de, x, y, line_start, frame_start
// All outputs are registered and reflect the counter state of the previous en cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_timing_gen_if.master      bus
);

  localparam int unsigned HTot0 = axis_total(VGA_640X480.h_display, VGA_640X480.h_front,
                                             VGA_640X480.h_sync, VGA_640X480.h_back);
  localparam int unsigned VTot0 = axis_total(VGA_640X480.v_display, VGA_640X480.v_front,
                                             VGA_640X480.v_sync, VGA_640X480.v_back);
  localparam int unsigned HTot1 = axis_total(VGA_800X600.h_display, VGA_800X600.h_front,
                                             VGA_800X600.h_sync, VGA_800X600.h_back);
  localparam int unsigned VTot1 = axis_total(VGA_800X600.v_display, VGA_800X600.v_front,
                                             VGA_800X600.v_sync, VGA_800X600.v_back);
  localparam int unsigned MaxH  = (HTot0 > HTot1) ? HTot0 : HTot1;
  localparam int unsigned MaxV  = (VTot0 > VTot1) ? VTot0 : VTot1;
  localparam int unsigned MaxTotal = (MaxH > MaxV) ? MaxH : MaxV;

  if (((MaxTotal - 1) >> CW) != 0) begin : g_cw_too_small
    $error("vga_timing_gen: CW=%0d cannot hold count %0d", CW, MaxTotal - 1);
  end

  logic          mode_q;
  vga_timing_t   timing;

  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  vga_phase_t    h_phase;
  vga_phase_t    v_phase;
  logic          h_wrap;
  logic          v_wrap;

  logic          hsync_q;
  logic          vsync_q;
  logic          de_q;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic          line_start_q;
  logic          frame_start_q;

  always_comb begin
    timing = mode_q ? VGA_800X600 : VGA_640X480;
  end

  vga_axis_counter #(
    .CW(CW)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (bus.en),
    .display(CW'(timing.h_display)),
    .front  (CW'(timing.h_front)),
    .sync   (CW'(timing.h_sync)),
    .back   (CW'(timing.h_back)),
    .count  (h_count),
    .phase  (h_phase),
    .wrap   (h_wrap)
  );

  // V only moves on H-wrap cycles, so its wrap is the frame-wrap.
  vga_axis_counter #(
    .CW(CW)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (h_wrap),
    .display(CW'(timing.v_display)),
    .front  (CW'(timing.v_front)),
    .sync   (CW'(timing.v_sync)),
    .back   (CW'(timing.v_back)),
    .count  (v_count),
    .phase  (v_phase),
    .wrap   (v_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (bus.en) begin
      // New mode takes effect on the same edge the counters return to (0,0).
      if (v_wrap) mode_q <= bus.mode_sel;
      hsync_q       <= (h_phase == SYNC) ^ timing.hs_neg;
      vsync_q       <= (v_phase == SYNC) ^ timing.vs_neg;
      de_q          <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
      x_q           <= h_count;
      y_q           <= v_count;
      line_start_q  <= (h_count == '0);
      frame_start_q <= (h_count == '0) && (v_count == '0);
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign bus.mode_active = mode_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: the driver pushes the expected output of
// every clock edge into a queue, computed from a pixel-coordinate model of the
// mode tables; an independent monitor pops and compares after each edge.
// The vertical counter is moved forward with force/release to reach frame ends
// within a short run.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int unsigned CW = 11;

  typedef struct packed {
    logic          mode_active;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } obs_t;

  // Mode tables: display, front, sync, back per axis; sync polarity.
  int HDisp [2] = '{640, 800};
  int HFront[2] = '{16, 40};
  int HSync [2] = '{96, 128};
  int HBack [2] = '{48, 88};
  int VDisp [2] = '{480, 600};
  int VFront[2] = '{10, 1};
  int VSync [2] = '{2, 4};
  int VBack [2] = '{33, 23};
  bit HNeg  [2] = '{1'b1, 1'b0};
  bit VNeg  [2] = '{1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(CW)) bus ();

  vga_timing_gen #(
    .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  obs_t exp_q[$];
  obs_t last_exp;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  // Reference model state: current pixel position, mode, completed frames.
  int   mh, mv, frames;
  bit   mmode;

  function automatic obs_t reset_obs();
    obs_t r;
    r = '{mode_active: 1'b0, hsync: 1'b1, vsync: 1'b1, de: 1'b0,
          line_start: 1'b0, frame_start: 1'b0, x: '0, y: '0};
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a = '{mode_active: bus.mode_active, hsync: bus.hsync, vsync: bus.vsync, de: bus.de,
          line_start: bus.line_start, frame_start: bus.frame_start, x: bus.x, y: bus.y};
    return a;
  endfunction

  task automatic report(input string name, input obs_t a, input obs_t e);
    if (errors <= 20)
      $display("FAIL %s t=%0t got x=%0d y=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b mode=%0b ; expected x=%0d y=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b mode=%0b",
               name, $time, a.x, a.y, a.hsync, a.vsync, a.de, a.line_start, a.frame_start,
               a.mode_active, e.x, e.y, e.hsync, e.vsync, e.de, e.line_start, e.frame_start,
               e.mode_active);
  endtask

  task automatic check_reset(input string name);
    obs_t a;
    a = sample();
    checks++;
    if (a != reset_obs()) begin
      errors++;
      report(name, a, reset_obs());
    end
  endtask

  task automatic model_reset();
    mh = 0;
    mv = 0;
    mmode = 1'b0;
    last_exp = reset_obs();
  endtask

  // Drive inputs for the coming edge and queue what that edge must produce.
  task automatic drive_and_model(input bit en, input bit msel);
    obs_t e;
    int   m, htot, vtot, hs0, vs0;
    bit   frame_end;
    bus.en = en;
    bus.mode_sel = msel;
    if (en) begin
      m    = int'(mmode);
      htot = HDisp[m] + HFront[m] + HSync[m] + HBack[m];
      vtot = VDisp[m] + VFront[m] + VSync[m] + VBack[m];
      hs0  = HDisp[m] + HFront[m];
      vs0  = VDisp[m] + VFront[m];
      e.x           = CW'(mh);
      e.y           = CW'(mv);
      e.de          = (mh < HDisp[m]) && (mv < VDisp[m]);
      e.hsync       = ((mh >= hs0) && (mh < hs0 + HSync[m])) ^ HNeg[m];
      e.vsync       = ((mv >= vs0) && (mv < vs0 + VSync[m])) ^ VNeg[m];
      e.line_start  = (mh == 0);
      e.frame_start = (mh == 0) && (mv == 0);
      frame_end = (mh == htot - 1) && (mv == vtot - 1);
      mh++;
      if (mh == htot) begin
        mh = 0;
        mv++;
        if (mv == vtot) mv = 0;
      end
      if (frame_end) begin
        mmode = msel;
        frames++;
      end
      e.mode_active = mmode;
    end else begin
      e = last_exp;
      e.line_start = 1'b0;
      e.frame_start = 1'b0;
    end
    last_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit en, input bit msel);
    @(negedge clk);
    drive_and_model(en, msel);
  endtask

  // Move the vertical count to a front-porch line of the current mode.
  task automatic jump_v(input int target, input bit msel);
    @(negedge clk);
    force dut.u_v_axis.count_q = CW'(target);
    force dut.u_v_axis.phase_q = FRONT;
    #1;
    release dut.u_v_axis.count_q;
    release dut.u_v_axis.phase_q;
    mv = target;
    drive_and_model(1'b1, msel);
  endtask

  task automatic run_to_frame_end(input int vsel_from, input bit final_sel, input string name);
    int start, n;
    start = frames;
    n = 0;
    while ((frames == start) && (n < 40000)) begin
      step($urandom_range(0, 15) != 0,
           (mv >= vsel_from) ? final_sel : 1'($urandom_range(0, 1)));
      n++;
    end
    checks++;
    if (frames == start) begin
      errors++;
      $display("FAIL %s frame end not reached in model after %0d cycles (required 1 wrap)",
               name, n);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("async_rst_immediate");
    @(posedge clk);
    #1;
    check_reset("async_rst_held");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    mon_on = 1'b1;
    drive_and_model(1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per clock edge while enabled.
  initial begin : monitor
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        a = sample();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow t=%0t got no expected entry (required 1)", $time);
        end else begin
          e = exp_q.pop_front();
          if (a != e) begin
            errors++;
            report("edge_compare", a, e);
          end
        end
      end
    end
  end

  initial begin : driver
    frames = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.mode_sel = 1'b0;
    #2;
    check_reset("reset_initial");
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_held");
    bus.en = 1'b1;
    bus.mode_sel = 1'b1;
    @(posedge clk);
    #1;
    check_reset("reset_held_en");

    // Release with en high: first edge shows (0,0) with both strobes.
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mon_on = 1'b1;
    drive_and_model(1'b1, 1'b0);

    // 50% en duty across two mode-0 lines; mode_sel noise must be ignored.
    for (int i = 0; i < 3200; i++) step(i % 2 == 1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 800; i++) step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

    // Mode 0 frame end with mode_sel=1: switch to 800x600.
    jump_v(489, 1'b0);
    run_to_frame_end(520, 1'b1, "mode0_to_mode1");

    // Mode 1 lines with mode_sel noise, then frame end keeping mode 1.
    for (int i = 0; i < 2300; i++) step($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)));
    jump_v(600, 1'b1);
    run_to_frame_end(620, 1'b1, "mode1_frame");
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)));

    // Asynchronous reset mid-line in mode 1; restart in mode 0.
    async_reset();
    for (int i = 0; i < 2000; i++) step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

    @(posedge clk);
    #2;
    mon_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d entries (required 0)", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
